alien_rocket_scheduler: RTL and testbench
=========================================

ALIEN_ROCKET_SCHEDULER -- requirements
Module: alien_rocket_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of alien rocket slots.
REQ-002 SHALL have parameter NUM_COLS, default 8, number of alien columns.
REQ-003 SHALL have parameter FIRE_INTERVAL, default 30, frames between fire attempts.
REQ-004 SHALL have parameter ALIEN_FIRE_SPEED, default 96, initial rocket speed in (pixels/64) per frame, positive (downward).
REQ-005 SHALL have parameters ALIEN_WIDTH, default 32, and ALIEN_HEIGHT, default 32, both in pixels.
REQ-006 SHALL use one clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  system clock, all state on rising edge.
REQ-008 reset  in  1  asynchronous active-high reset.
REQ-009 startOfFrame  in  1  one-cycle pulse per frame.
REQ-010 enable  in  1  game running; low suppresses new launches.
REQ-011 collision  in  NUM_SLOTS  per-slot hit pulse; frees the slot.
REQ-012 offScreen  in  NUM_SLOTS  per-slot exit pulse; frees the slot.
REQ-013 queryReq  out  1  column query request to the alien matrix.
REQ-014 queryCol  out  3  column index under query.
REQ-015 queryAck  in  1  one-cycle pulse: query answered.
REQ-016 queryFound  in  1  valid with queryAck: column holds a living alien.
REQ-017 alienTLX, alienTLY  in  11 signed each  top-left of the lowest living alien, valid with queryAck.
REQ-018 launch  out  1  one-cycle pulse: load a rocket.
REQ-019 launchSlot  out  2  slot index loaded by launch.
REQ-020 initialX, initialY  out  11 signed each  rocket start position.
REQ-021 initialSpeed  out  9 signed  rocket start speed.
REQ-022 isActiveAliens  out  NUM_SLOTS  per-slot active flags.

Function
REQ-023 SHALL implement FSM states IDLE, QUERY, LAUNCH.
REQ-024 IDLE: frame counter decrements on each startOfFrame while enable=1; on counter reaching 0 it reloads FIRE_INTERVAL-1 and the FSM moves to QUERY only if a free slot exists, else stays IDLE (attempt skipped).
REQ-025 On IDLE->QUERY, queryCol SHALL load lfsr[2:0] and a retry counter SHALL clear to 0.
REQ-026 The 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) SHALL advance every clock, never reaching 0.
REQ-027 QUERY: queryReq=1 and queryCol held stable until queryAck; queryReq deasserts the cycle after queryAck.
REQ-028 queryAck with queryFound=1: capture initialX=alienTLX+ALIEN_WIDTH/2, initialY=alienTLY+ALIEN_HEIGHT (11-bit signed, wrap on overflow), go LAUNCH.
REQ-029 queryAck with queryFound=0: queryCol increments modulo NUM_COLS and retry increments; after NUM_COLS misses go IDLE without launching.
REQ-030 LAUNCH: one cycle; launch=1, launchSlot=lowest-index free slot, initialSpeed=ALIEN_FIRE_SPEED, that slot's isActiveAliens bit sets next edge; then IDLE.
REQ-031 If no slot is free on entering LAUNCH, launch SHALL stay 0 and the FSM returns to IDLE.
REQ-032 collision[i] or offScreen[i] SHALL clear isActiveAliens[i] next edge; pulses on inactive slots are ignored.
REQ-033 A slot freed in the same cycle as allocation SHALL not be counted free until the following cycle.
REQ-034 enable=0 in QUERY or LAUNCH: FSM returns to IDLE next edge, queryReq=0, launch=0; frame counter holds; slot clearing continues.
REQ-035 initialX/initialY/initialSpeed SHALL hold their last value outside LAUNCH.

Reset
REQ-036 reset SHALL asynchronously force: FSM IDLE, frame counter FIRE_INTERVAL-1, LFSR 8'hA5, queryReq=0, queryCol=0, launch=0, launchSlot=0, initialX=0, initialY=0, initialSpeed=0, isActiveAliens=0.
REQ-037 reset asserted mid-QUERY SHALL drop queryReq in the same cycle; a later queryAck is ignored.

Verification
REQ-038 enable=1, 30 startOfFrame pulses, queryAck+queryFound=1, TLX=100, TLY=50 -> launch pulse, launchSlot=0, initialX=116, initialY=82, initialSpeed=96, isActiveAliens=0001.
REQ-039 Four successful launches, no frees -> isActiveAliens=1111; next interval expiry -> no queryReq, no launch.
REQ-040 queryFound=0 for 8 consecutive acks -> queryCol steps through 8 columns, FSM to IDLE, launch never asserted.
REQ-041 isActiveAliens=0011, collision=0010 -> isActiveAliens=0001 next cycle; next launch uses slot 1.
REQ-042 reset pulsed while queryReq=1 -> all outputs at REQ-036 values immediately; following queryAck produces no launch.
REQ-043 enable dropped during QUERY -> queryReq=0 next cycle, frame counter frozen until enable returns.

Source files
------------

// File: rtl/alien_rocket_scheduler_if.sv
// rtl/alien_rocket_scheduler_if.sv - column query and rocket launch bus
interface alien_rocket_scheduler_if;
  // Column query handshake with the alien matrix
  logic               queryReq;
  logic [2:0]         queryCol;
  logic               queryAck;
  logic               queryFound;
  logic signed [10:0] alienTLX;
  logic signed [10:0] alienTLY;
  // Rocket load towards the rocket slots
  logic               launch;
  logic [1:0]         launchSlot;
  logic signed [10:0] initialX;
  logic signed [10:0] initialY;
  logic signed [8:0]  initialSpeed;

  modport master (
    output queryReq, queryCol, launch, launchSlot, initialX, initialY, initialSpeed,
    input  queryAck, queryFound, alienTLX, alienTLY
  );

  modport slave (
    input  queryReq, queryCol, launch, launchSlot, initialX, initialY, initialSpeed,
    output queryAck, queryFound, alienTLX, alienTLY
  );
endinterface

// File: rtl/alien_rocket_scheduler.sv
// rtl/alien_rocket_scheduler.sv - picks a random alien column and launches rockets into free slots
module alien_rocket_scheduler #(
  parameter int NUM_SLOTS        = 4,
  parameter int NUM_COLS         = 8,
  parameter int FIRE_INTERVAL    = 30,
  parameter int ALIEN_FIRE_SPEED = 96,
  parameter int ALIEN_WIDTH      = 32,
  parameter int ALIEN_HEIGHT     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     startOfFrame,
  input  logic                     enable,
  input  logic [NUM_SLOTS-1:0]     collision,
  input  logic [NUM_SLOTS-1:0]     offScreen,
  output logic [NUM_SLOTS-1:0]     isActiveAliens,
  alien_rocket_scheduler_if.master bus
);

  localparam int CNT_W   = (FIRE_INTERVAL > 1) ? $clog2(FIRE_INTERVAL) : 1;
  localparam int RETRY_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(FIRE_INTERVAL - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(NUM_COLS - 1);
  localparam logic [2:0]         COL_LAST   = 3'(NUM_COLS - 1);

  typedef enum logic [1:0] {IDLE, QUERY, LAUNCH} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     frame_cnt, frame_cnt_n;
  logic [7:0]           lfsr;
  logic [2:0]           col, col_n;
  logic [RETRY_W-1:0]   retry, retry_n;
  logic [NUM_SLOTS-1:0] active;
  logic [NUM_SLOTS-1:0] free;
  logic                 any_free;
  logic [1:0]           free_idx;
  logic                 capture;
  logic                 query_req;
  logic                 launch_pulse;
  logic signed [10:0]   init_x, init_y;
  logic signed [8:0]    init_speed;

  // Free slots come from the registered flags, so a slot released this cycle is only seen next cycle
  always_comb begin
    free     = ~active;
    any_free = |free;
    free_idx = 2'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (free[i]) free_idx = 2'(i);
    end
  end

  // Next-state, frame countdown, column walk and output decode
  always_comb begin
    state_n      = state;
    frame_cnt_n  = frame_cnt;
    col_n        = col;
    retry_n      = retry;
    capture      = 1'b0;
    query_req    = 1'b0;
    launch_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (startOfFrame && enable) begin
          if (frame_cnt == '0) begin
            frame_cnt_n = CNT_RELOAD;
            if (any_free) begin
              state_n = QUERY;
              col_n   = lfsr[2:0];
              retry_n = '0;
            end
          end else begin
            frame_cnt_n = frame_cnt - 1'b1;
          end
        end
      end
      QUERY: begin
        query_req = 1'b1;
        if (!enable) begin
          state_n = IDLE;
        end else if (bus.queryAck) begin
          if (bus.queryFound) begin
            capture = 1'b1;
            state_n = LAUNCH;
          end else begin
            col_n   = (col == COL_LAST) ? 3'd0 : col + 3'd1;
            retry_n = retry + 1'b1;
            if (retry == RETRY_LAST) state_n = IDLE;
          end
        end
      end
      LAUNCH: begin
        state_n      = IDLE;
        launch_pulse = enable && any_free;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and random source
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      frame_cnt <= CNT_RELOAD;
      lfsr      <= 8'hA5;
      col       <= 3'd0;
      retry     <= '0;
    end else begin
      state     <= state_n;
      frame_cnt <= frame_cnt_n;
      lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      col       <= col_n;
      retry     <= retry_n;
    end
  end

  // Rocket start values are latched on the found answer and held until the next one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_x     <= '0;
      init_y     <= '0;
      init_speed <= '0;
    end else if (capture) begin
      init_x     <= bus.alienTLX + 11'(ALIEN_WIDTH / 2);
      init_y     <= bus.alienTLY + 11'(ALIEN_HEIGHT);
      init_speed <= 9'(ALIEN_FIRE_SPEED);
    end
  end

  // Slot flags: hits and exits clear, a launch sets the chosen slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= '0;
    end else begin
      active <= (active & ~(collision | offScreen))
              | (launch_pulse ? (NUM_SLOTS'(1) << free_idx) : '0);
    end
  end

  assign bus.queryReq     = query_req;
  assign bus.queryCol     = col;
  assign bus.launch       = launch_pulse;
  assign bus.launchSlot   = free_idx;
  assign bus.initialX     = init_x;
  assign bus.initialY     = init_y;
  assign bus.initialSpeed = init_speed;
  assign isActiveAliens   = active;

endmodule

// File: tb/tb_alien_rocket_scheduler.sv
// tb/tb_alien_rocket_scheduler.sv - directed scoreboard bench for the alien rocket scheduler
module tb_alien_rocket_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] collision = 4'b0;
  logic [3:0] offScreen = 4'b0;
  logic [3:0] isActiveAliens;

  alien_rocket_scheduler_if bus ();

  alien_rocket_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (startOfFrame),
    .enable         (enable),
    .collision      (collision),
    .offScreen      (offScreen),
    .isActiveAliens (isActiveAliens),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  slot;
    logic [10:0] x;
    logic [10:0] y;
    logic [8:0]  spd;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] model_act = 4'b0;
  logic [2:0] c0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  task automatic wait_query(input string tag);
    for (int i = 0; i < 8 && !bus.queryReq; i++) tick();
    check(tag, 32'(bus.queryReq), 32'd1);
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_req"},   32'(bus.queryReq), 32'd0);
    check({tag, "_col"},   32'(bus.queryCol), 32'd0);
    check({tag, "_launch"}, 32'(bus.launch), 32'd0);
    check({tag, "_slot"},  32'(bus.launchSlot), 32'd0);
    check({tag, "_x"},     32'(bus.initialX[10:0]), 32'd0);
    check({tag, "_y"},     32'(bus.initialY[10:0]), 32'd0);
    check({tag, "_spd"},   32'(bus.initialSpeed[8:0]), 32'd0);
    check({tag, "_act"},   32'(isActiveAliens), 32'd0);
  endtask

  // Answer the pending query with a living alien and check the resulting launch
  task automatic launch_one(input string tag, input int tlx, input int tly);
    exp_t e;
    int   slot = -1;
    bit   seen = 0;
    for (int i = 3; i >= 0; i--) if (!model_act[i]) slot = i;
    e.slot = 2'(slot);
    e.x    = 11'(tlx + 16);
    e.y    = 11'(tly + 32);
    e.spd  = 9'd96;
    sb.push_back(e);
    bus.queryAck   = 1'b1;
    bus.queryFound = 1'b1;
    bus.alienTLX   = 11'(tlx);
    bus.alienTLY   = 11'(tly);
    tick();
    bus.queryAck   = 1'b0;
    bus.queryFound = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (bus.launch) seen = 1;
      else tick();
    end
    check({tag, "_launch"}, 32'(seen), 32'd1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_slot"}, 32'(bus.launchSlot), 32'(e.slot));
      check({tag, "_x"},    32'(bus.initialX[10:0]), 32'(e.x));
      check({tag, "_y"},    32'(bus.initialY[10:0]), 32'(e.y));
      check({tag, "_spd"},  32'(bus.initialSpeed[8:0]), 32'(e.spd));
      model_act[e.slot] = 1'b1;
    end
    tick();
    check({tag, "_pulse_end"}, 32'(bus.launch), 32'd0);
    check({tag, "_act"}, 32'(isActiveAliens), 32'(model_act));
    check({tag, "_hold_x"}, 32'(bus.initialX[10:0]), 32'(e.x));
  endtask

  initial begin
    bus.queryAck   = 1'b0;
    bus.queryFound = 1'b0;
    bus.alienTLX   = '0;
    bus.alienTLY   = '0;

    // Reset state
    tick();
    tick();
    reset_values("rst");
    reset = 1'b0;
    enable = 1'b1;

    // First launch after a full fire interval
    frames(29);
    check("no_query_early", 32'(bus.queryReq), 32'd0);
    frames(1);
    wait_query("q1");
    launch_one("l1", 100, 50);

    // Eight misses walk every column and give up without launching
    frames(30);
    wait_query("q_miss");
    c0 = bus.queryCol;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("miss_col%0d", k), 32'(bus.queryCol), 32'((c0 + k) % 8));
      check($sformatf("miss_req%0d", k), 32'(bus.queryReq), 32'd1);
      bus.queryAck = 1'b1;
      tick();
      bus.queryAck = 1'b0;
      check($sformatf("miss_launch%0d", k), 32'(bus.launch), 32'd0);
    end
    check("miss_idle", 32'(bus.queryReq), 32'd0);
    check("miss_act", 32'(isActiveAliens), 32'(model_act));

    // Fill the remaining slots, including negative and wrapping positions
    frames(30);
    wait_query("q2");
    launch_one("l2", -20, -5);
    frames(30);
    wait_query("q3");
    launch_one("l3", 1015, 1000);
    frames(30);
    wait_query("q4");
    launch_one("l4", 0, 0);
    check("full", 32'(isActiveAliens), 32'hF);

    // All slots busy: the expiry is skipped
    frames(30);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("full_noreq%0d", i), 32'(bus.queryReq), 32'd0);
      check($sformatf("full_nolaunch%0d", i), 32'(bus.launch), 32'd0);
      tick();
    end

    // Frees: exits on 2 and 3, then a hit on 1 plus a stray hit on inactive slot 3
    offScreen = 4'b1100;
    tick();
    offScreen = 4'b0000;
    model_act = 4'b0011;
    check("free_exit", 32'(isActiveAliens), 32'(model_act));
    collision = 4'b1010;
    tick();
    collision = 4'b0000;
    model_act = 4'b0001;
    check("free_hit", 32'(isActiveAliens), 32'(model_act));
    frames(30);
    wait_query("q5");
    launch_one("l5", 200, 300);

    // Enable dropped during a query freezes the frame counter
    frames(30);
    wait_query("q6");
    enable = 1'b0;
    tick();
    check("dis_req", 32'(bus.queryReq), 32'd0);
    frames(5);
    check("dis_launch", 32'(bus.launch), 32'd0);
    enable = 1'b1;
    frames(29);
    check("frozen_29", 32'(bus.queryReq), 32'd0);
    frames(1);
    check("frozen_30", 32'(bus.queryReq), 32'd1);
    launch_one("l6", 64, 64);

    // Reset in the middle of a query; the late answer is ignored
    frames(30);
    wait_query("q7");
    #2;
    reset = 1'b1;
    #1;
    model_act = 4'b0;
    reset_values("mid_rst");
    tick();
    reset = 1'b0;
    bus.queryAck   = 1'b1;
    bus.queryFound = 1'b1;
    bus.alienTLX   = 11'd10;
    bus.alienTLY   = 11'd10;
    tick();
    bus.queryAck   = 1'b0;
    bus.queryFound = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("late_ack_launch%0d", i), 32'(bus.launch), 32'd0);
      tick();
    end
    check("late_ack_act", 32'(isActiveAliens), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
